fpm_operand_sequencer: RTL and testbench

//  Upstream feeder and result collector for the registered FP32 multiplier (registeredFPM).
//  - Buffers operand pairs from a valid/ready stream.
//  - Issues them one at a time over the multiplier's enable interface.
//  - Captures out/overflow after a fixed latency, then presents them on a valid/ready result stream.
//  - Converts the multiplier's timed enable protocol into elastic handshakes for the datapath.

---
 rtl/fpm_pkg.sv | 28 ++
 rtl/fpm_operand_sequencer_if.sv | 24 ++
 rtl/fpm_operand_fifo.sv | 56 +++++
 rtl/fpm_operand_sequencer.sv | 145 ++++++++++++++
 tb/tb_fpm_operand_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fpm_pkg.sv
// Shared types and field constants for the FP32 multiplier operand sequencer.
package fpm_pkg;

    localparam int unsigned FP_W     = 32;
    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MAN_W    = 23;

    typedef logic [FP_W-1:0] fp32_t;

    typedef struct packed {
        fp32_t a;
        fp32_t b;
    } fpm_pair_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResult
    } seq_state_t;

    // True when either operand is +0 or -0 (sign bit ignored).
    function automatic logic pair_has_zero(fpm_pair_t p);
        return (p.a[EXP_MSB:0] == '0) || (p.b[EXP_MSB:0] == '0);
    endfunction

endpackage

// File: rtl/fpm_operand_sequencer_if.sv
// Operand and result valid/ready streams of the FP32 multiplier sequencer.
interface fpm_operand_sequencer_if;
    import fpm_pkg::*;

    logic  s_valid;
    logic  s_ready;
    fp32_t s_in1;
    fp32_t s_in2;
    logic  m_valid;
    logic  m_ready;
    fp32_t m_result;
    logic  m_overflow;

    modport master (
        output s_valid, s_in1, s_in2, m_ready,
        input  s_ready, m_valid, m_result, m_overflow
    );

    modport slave (
        input  s_valid, s_in1, s_in2, m_ready,
        output s_ready, m_valid, m_result, m_overflow
    );

endinterface

// File: rtl/fpm_operand_fifo.sv
// Synchronous FIFO of operand pairs with occupancy count; DEPTH must be a power of 2.
module fpm_operand_fifo
    import fpm_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  fpm_pair_t                    wdata,
    output fpm_pair_t                    rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fpm_pair_t       mem [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] cnt_q;
    logic            do_push, do_pop;

    assign full    = (cnt_q == CntW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr_q];
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fpm_operand_sequencer.sv
// Feeds buffered operand pairs to a fixed-latency FP32 multiplier and collects results.
// Optional FPM_ZERO_BYPASS_EN: pairs with a +/-0 operand complete without using the multiplier.
module fpm_operand_sequencer
    import fpm_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned MULT_LATENCY = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    fpm_operand_sequencer_if.slave       bus,
    output logic                         mul_enable,
    output fp32_t                        mul_in1,
    output fp32_t                        mul_in2,
    input  fp32_t                        mul_out,
    input  logic                         mul_overflow,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int unsigned CntW = $clog2(MULT_LATENCY + 1);

    seq_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            en_q, en_d;
    fp32_t           in1_q, in1_d, in2_q, in2_d;
    fp32_t           res_q, res_d;
    logic            ovf_q, ovf_d;
    logic            mv_q, mv_d;

    logic            fifo_full, fifo_empty, push, pop, bypass;
    fpm_pair_t       head, in_pair;

    assign in_pair     = '{a: bus.s_in1, b: bus.s_in2};
    assign bus.s_ready = !fifo_full;
    assign push        = bus.s_valid && !fifo_full;
    assign pop         = (state_q == StIdle) && !fifo_empty;

`ifdef FPM_ZERO_BYPASS_EN
    assign bypass = pair_has_zero(head);
`else
    assign bypass = 1'b0;
`endif

    fpm_operand_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_pair),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!fifo_empty) state_d = bypass ? StResult : StWait;
            StWait:   if (cnt_q == CntW'(1)) state_d = StResult;
            StResult: if (bus.m_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        en_d  = en_q;
        in1_d = in1_q;
        in2_d = in2_q;
        res_d = res_q;
        ovf_d = ovf_q;
        mv_d  = mv_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    if (bypass) begin
                        res_d = '0;
                        ovf_d = 1'b0;
                        mv_d  = 1'b1;
                    end else begin
                        in1_d = head.a;
                        in2_d = head.b;
                        en_d  = 1'b1;
                        cnt_d = CntW'(MULT_LATENCY);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - CntW'(1);
                // Last enable cycle: the multiplier output is valid now.
                if (cnt_q == CntW'(1)) begin
                    res_d = mul_out;
                    ovf_d = mul_overflow;
                    mv_d  = 1'b1;
                    en_d  = 1'b0;
                end
            end
            StResult: begin
                if (bus.m_ready) mv_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
            in1_q <= '0;
            in2_q <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
            mv_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_d;
            in1_q <= in1_d;
            in2_q <= in2_d;
            res_q <= res_d;
            ovf_q <= ovf_d;
            mv_q  <= mv_d;
        end
    end

    assign mul_enable     = en_q;
    assign mul_in1        = in1_q;
    assign mul_in2        = in2_q;
    assign bus.m_valid    = mv_q;
    assign bus.m_result   = res_q;
    assign bus.m_overflow = ovf_q;
    assign busy           = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_fpm_operand_sequencer.sv
// Scoreboard bench for fpm_operand_sequencer with a behavioural fixed-latency FP32 multiplier.
module tb_fpm_operand_sequencer;
    import fpm_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fpm_operand_sequencer_if bus ();
    logic       mul_enable, mul_overflow, busy;
    fp32_t      mul_in1, mul_in2, mul_out;
    logic [2:0] fifo_count;

    fpm_operand_sequencer #(
        .DEPTH        (DEPTH),
        .MULT_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .mul_enable   (mul_enable),
        .mul_in1      (mul_in1),
        .mul_in2      (mul_in2),
        .mul_out      (mul_out),
        .mul_overflow (mul_overflow),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    // Multiplier stand-in: truncating FP32 product with wrapped exponent, valid only
    // once enable has been high for LAT-1 edges.
    int                 en_cnt;
    logic [47:0]        mp;
    logic signed [9:0]  es;
    logic [22:0]        man;
    fp32_t              prod;
    logic               prod_ovf;

    always @(posedge clk) begin
        if (reset || !mul_enable) en_cnt <= 0;
        else en_cnt <= en_cnt + 1;
    end

    always_comb begin
        mp       = {24'b0, 1'b1, mul_in1[22:0]} * {24'b0, 1'b1, mul_in2[22:0]};
        es       = $signed({2'b0, mul_in1[30:23]}) + $signed({2'b0, mul_in2[30:23]}) - 10'sd127;
        man      = mp[45:23];
        if (mp[47]) begin
            man = mp[46:24];
            es  = es + 10'sd1;
        end
        prod     = {mul_in1[31] ^ mul_in2[31], es[7:0], man};
        prod_ovf = (es > 10'sd254);
        if (mul_in1[30:0] == '0 || mul_in2[30:0] == '0) begin
            prod     = '0;
            prod_ovf = 1'b0;
        end
        mul_out      = (en_cnt >= LAT - 1) ? prod : 32'hdeadbeef;
        mul_overflow = (en_cnt >= LAT - 1) ? prod_ovf : 1'b1;
    end

    typedef struct packed {
        fp32_t r;
        logic  o;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   run = 0;
    bit   en_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Result monitor: a transfer happens at the next posedge when valid and ready are both high.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h, expected no result", bus.m_result);
            end else begin
                e = sb.pop_front();
                check("m_result", bus.m_result, e.r);
                check("m_overflow", {31'b0, bus.m_overflow}, {31'b0, e.o});
            end
        end
    end

    // Enable pulse width monitor; a reset abandons the pulse.
    always @(negedge clk) begin
        if (reset) begin
            run = 0;
        end else if (mul_enable) begin
            run++;
            en_seen = 1'b1;
        end else if (run != 0) begin
            check("enable_width", run, LAT);
            run = 0;
        end
    end

    task automatic push(input fp32_t a, input fp32_t b, input bit track, input fp32_t er,
                        input logic eo);
        int n;
        bus.s_valid = 1'b1;
        bus.s_in1   = a;
        bus.s_in2   = b;
        n = 0;
        @(negedge clk);
        while (!bus.s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: s_ready got 0, expected 1");
        end else if (track) begin
            sb.push_back(exp_t'{r: er, o: eo});
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bus.m_valid && k < 50);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_busy", {31'b0, busy}, 32'd0);
    endtask

    fp32_t burst_a [6] = '{32'hc0080000, 32'hbf200000, 32'h3f800000,
                           32'h40000000, 32'h3fc00000, 32'hc0a00000};
    fp32_t burst_b [6] = '{32'hc0680000, 32'h3fd00000, 32'h40400000,
                           32'h40000000, 32'h3fc00000, 32'h3e800000};
    fp32_t burst_r [6] = '{32'h40f68000, 32'hbf820000, 32'h40400000,
                           32'h40800000, 32'h40100000, 32'hbfa00000};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        bus.s_valid = 1'b0;
        bus.s_in1   = '0;
        bus.s_in2   = '0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", {31'b0, bus.m_valid}, 32'd0);
        check("rst_mul_enable", {31'b0, mul_enable}, 32'd0);
        check("rst_fifo_count", {29'b0, fifo_count}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_m_result", bus.m_result, 32'd0);
        check("rst_mul_in1", mul_in1, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_s_ready", {31'b0, bus.s_ready}, 32'd1);

        // Single op and latency from the accepting edge.
        bus.m_ready = 1'b1;
        push(32'h40aa6666, 32'h40aa6666, 1'b1, 32'h41e2d850, 1'b0);
        wait_valid(k);
        check("latency_single", k, 5);
        drain();

        // Back-to-back burst against a stalled consumer.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(burst_a[i], burst_b[i], 1'b1, burst_r[i], 1'b0);
        check("full_s_ready", {31'b0, bus.s_ready}, 32'd0);
        check("full_count", {29'b0, fifo_count}, 32'd4);
        bus.m_ready = 1'b1;
        push(burst_a[5], burst_b[5], 1'b1, burst_r[5], 1'b0);
        drain();

        // Overflowing product held while the consumer stalls.
        bus.m_ready = 1'b0;
        push(32'h7f000000, 32'h7f000000, 1'b1, 32'h3e800000, 1'b1);
        wait_valid(k);
        check("latency_ovf", k, 5);
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", {31'b0, bus.m_valid}, 32'd1);
            check("hold_result", bus.m_result, 32'h3e800000);
            check("hold_overflow", {31'b0, bus.m_overflow}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus.m_ready = 1'b1;
        drain();

        // Reset in the second WAIT cycle discards the op.
        push(32'h3f800000, 32'h40000000, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("wait_enable", {31'b0, mul_enable}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_mul_enable", {31'b0, mul_enable}, 32'd0);
        check("abort_m_valid", {31'b0, bus.m_valid}, 32'd0);
        check("abort_fifo_count", {29'b0, fifo_count}, 32'd0);
        check("abort_s_ready", {31'b0, bus.s_ready}, 32'd1);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_quiet", {31'b0, busy}, 32'd0);

        // Zero operand: bypassed or multiplied depending on the build.
        en_seen = 1'b0;
        push(32'h00000000, 32'hc0480000, 1'b1, 32'h00000000, 1'b0);
        wait_valid(k);
`ifdef FPM_ZERO_BYPASS_EN
        check("latency_zero", k, 1);
        drain();
        check("zero_no_enable", {31'b0, en_seen}, 32'd0);
`else
        check("latency_zero", k, 5);
        drain();
        check("zero_enable_seen", {31'b0, en_seen}, 32'd1);
`endif

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
